// File: rtl/dsq_argmin.sv
// rtl/dsq_argmin.sv - PCPI-style coprocessor accumulating squared-distance chunks and tracking the argmin
// Registered wait/ready handshake with a fixed two-cycle valid-to-ready latency.
module dsq_argmin (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [31:0] instr,
  input  logic        valid,
  output logic        ready,
  output logic        wait_,
  output logic [31:0] rd,
  output logic        wr
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]  state;
  logic [31:0] op_a;
  logic [15:0] op_idx;
  logic [2:0]  op_f3;

  logic [31:0] acc;
  logic [31:0] best_dist;
  logic [15:0] best_idx;
  logic [15:0] count;
  logic        have_best;

  logic        hit;
  logic [32:0] sum;
  logic [31:0] sat;
  logic        better;
  logic        unused_bits;

  // funct3 110/111 are left for other coprocessors sharing the bus
  assign hit = (instr[6:0] == 7'b0001011) && (instr[31:25] == 7'b0000010) &&
               (instr[14:13] != 2'b11);

  assign sum    = {1'b0, acc} + {1'b0, op_a};
  assign sat    = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  assign better = !have_best || (sat < best_dist);

  assign unused_bits = ^{rs2[31:16], instr[24:15], instr[11:7]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      op_a      <= 32'd0;
      op_idx    <= 16'd0;
      op_f3     <= 3'd0;
      acc       <= 32'd0;
      best_dist <= 32'hFFFF_FFFF;
      best_idx  <= 16'd0;
      count     <= 16'd0;
      have_best <= 1'b0;
      ready     <= 1'b0;
      wait_     <= 1'b0;
      wr        <= 1'b0;
      rd        <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (valid && hit) begin
            op_a   <= rs1;
            op_idx <= rs2[15:0];
            op_f3  <= instr[14:12];
            wait_  <= 1'b1;
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          wait_ <= 1'b0;
          if (!valid) begin
            state <= S_IDLE;
          end else begin
            ready <= 1'b1;
            wr    <= 1'b1;
            state <= S_RESP;
            case (op_f3)
              3'b000: begin
                acc <= sat;
                rd  <= sat;
              end
              3'b001: begin
                if (better) begin
                  best_dist <= sat;
                  best_idx  <= op_idx;
                  have_best <= 1'b1;
                  rd        <= {16'd0, op_idx};
                end else begin
                  rd <= {16'd0, best_idx};
                end
                acc   <= 32'd0;
                count <= count + 16'd1;
              end
              3'b010: rd <= best_dist;
              3'b011: rd <= {have_best, 15'd0, best_idx};
              3'b100: begin
                acc       <= 32'd0;
                best_dist <= 32'hFFFF_FFFF;
                best_idx  <= 16'd0;
                have_best <= 1'b0;
                count     <= 16'd0;
                rd        <= 32'd0;
              end
              3'b101:  rd <= {16'd0, count};
              default: rd <= 32'd0;
            endcase
          end
        end
        S_RESP: begin
          ready <= 1'b0;
          wr    <= 1'b0;
          state <= S_DRAIN;
        end
        default: begin
          // hold off until the CPU drops valid so the same instruction is not re-accepted
          if (!valid) state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsq_argmin.sv
// tb/tb_dsq_argmin.sv - table-driven scoreboard bench for dsq_argmin
module tb_dsq_argmin;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] rs1 = 32'd0;
  logic [31:0] rs2 = 32'd0;
  logic [31:0] instr = 32'd0;
  logic        valid = 1'b0;
  logic        ready;
  logic        wait_;
  logic [31:0] rd;
  logic        wr;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  localparam logic [2:0] F_ACC = 3'd0, F_COMMIT = 3'd1, F_GETMIN = 3'd2,
                         F_GETIDX = 3'd3, F_CLEAR = 3'd4, F_GETCNT = 3'd5;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  dsq_argmin dut (
    .clk(clk), .resetn(resetn), .rs1(rs1), .rs2(rs2), .instr(instr),
    .valid(valid), .ready(ready), .wait_(wait_), .rd(rd), .wr(wr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [6:0] f7, input logic [2:0] f3,
                                           input logic [6:0] opc);
    return {f7, 10'd0, f3, 5'd0, opc};
  endfunction

  // scoreboard side: every ready pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (resetn && ready) begin
      check("wr_eq_ready", {31'd0, wr}, 32'd1);
      check("wait_low_in_resp", {31'd0, wait_}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ready actual=%h expected=none", rd);
      end else begin
        check("rd", rd, exp_q.pop_front());
      end
    end
  end

  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    int lat;
    @(negedge clk);
    instr = mk_instr(7'b0000010, f3, 7'b0001011);
    rs1   = a;
    rs2   = b;
    valid = 1'b1;
    exp_q.push_back(exp);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) check("wait_after_accept", {31'd0, wait_}, 32'd1);
    end while (!ready && lat < 8);
    check("latency", lat, 2);
    valid = 1'b0;
    rs1   = $urandom;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic watch_idle(input string name, input int cycles);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (wait_ || ready || wr) bad++;
    end
    check(name, bad, 0);
  endtask

  initial begin
    vecs = '{
      '{F_GETIDX, 32'd0, 32'd0, 32'h0000_0000},
      '{F_GETMIN, 32'd0, 32'd0, 32'hFFFF_FFFF},
      '{F_ACC,    32'd600, 32'd0, 32'd600},
      '{F_COMMIT, 32'd23, 32'd7, 32'd7},
      '{F_GETMIN, 32'd0, 32'd0, 32'd623},
      '{F_GETCNT, 32'd0, 32'd0, 32'd1},
      '{F_CLEAR,  32'd0, 32'd0, 32'd0},
      '{F_COMMIT, 32'd260100, 32'd1, 32'd1},
      '{F_COMMIT, 32'd98053, 32'd2, 32'd2},
      '{F_COMMIT, 32'd98053, 32'd3, 32'd2},
      '{F_COMMIT, 32'd600, 32'd4, 32'd4},
      '{F_GETIDX, 32'd0, 32'd0, 32'h8000_0004},
      '{F_GETMIN, 32'd0, 32'd0, 32'd600},
      '{F_GETCNT, 32'd0, 32'd0, 32'd4},
      '{F_CLEAR,  32'd0, 32'd0, 32'd0},
      '{F_COMMIT, 32'd260100, 32'd1, 32'd1},
      '{F_COMMIT, 32'd98053, 32'd2, 32'd2},
      '{F_COMMIT, 32'd98053, 32'd3, 32'd2},
      '{F_GETIDX, 32'd0, 32'd0, 32'h8000_0002},
      '{F_CLEAR,  32'd0, 32'd0, 32'd0},
      '{F_ACC,    32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0},
      '{F_COMMIT, 32'h20, 32'd9, 32'd9},
      '{F_GETMIN, 32'd0, 32'd0, 32'hFFFF_FFFF},
      '{F_GETIDX, 32'd0, 32'd0, 32'h8000_0009},
      '{F_ACC,    32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0},
      '{F_ACC,    32'h20, 32'd0, 32'hFFFF_FFFF},
      '{F_ACC,    32'd5, 32'd0, 32'hFFFF_FFFF},
      '{F_COMMIT, 32'd0, 32'd10, 32'd9},
      '{F_GETCNT, 32'd0, 32'd0, 32'd2}
    };

    repeat (3) @(negedge clk);
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_wait", {31'd0, wait_}, 32'd0);
    check("reset_wr", {31'd0, wr}, 32'd0);
    check("reset_rd", rd, 32'd0);
    resetn = 1'b1;

    foreach (vecs[i]) do_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp);

    // decode misses: wrong opcode, then unclaimed funct3
    @(negedge clk);
    instr = mk_instr(7'b0000010, F_ACC, 7'b0110011);
    rs1   = 32'd1000;
    valid = 1'b1;
    watch_idle("miss_opcode_idle", 10);
    instr = mk_instr(7'b0000010, 3'b111, 7'b0001011);
    watch_idle("miss_funct3_idle", 10);
    valid = 1'b0;
    do_op(F_GETCNT, 32'd0, 32'd0, 32'd2);
    do_op(F_ACC, 32'd0, 32'd0, 32'd0);

    // abort: valid dropped while in EXEC
    do_op(F_ACC, 32'd100, 32'd0, 32'd100);
    @(negedge clk);
    instr = mk_instr(7'b0000010, F_ACC, 7'b0001011);
    rs1   = 32'd5;
    valid = 1'b1;
    @(negedge clk);
    check("abort_wait_high", {31'd0, wait_}, 32'd1);
    valid = 1'b0;
    watch_idle("abort_no_ready", 4);
    do_op(F_ACC, 32'd0, 32'd0, 32'd100);

    // asynchronous reset in the middle of a COMMIT
    @(negedge clk);
    instr = mk_instr(7'b0000010, F_COMMIT, 7'b0001011);
    rs1   = 32'd1;
    rs2   = 32'd11;
    valid = 1'b1;
    @(negedge clk);
    check("pre_reset_wait", {31'd0, wait_}, 32'd1);
    resetn = 1'b0;
    #1;
    check("async_wait", {31'd0, wait_}, 32'd0);
    check("async_ready", {31'd0, ready}, 32'd0);
    check("async_wr", {31'd0, wr}, 32'd0);
    check("async_rd", rd, 32'd0);
    valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    do_op(F_GETCNT, 32'd0, 32'd0, 32'd0);
    do_op(F_GETMIN, 32'd0, 32'd0, 32'hFFFF_FFFF);
    do_op(F_ACC, 32'd0, 32'd0, 32'd0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
